// File: rtl/ahb_pkg.sv
// ============================================================================
//  ahb_pkg
//  Shared AHB-Lite encodings and the error-slave FSM state type.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  localparam logic c_hresp_okay  = 1'b0;
  localparam logic c_hresp_error = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // NONSEQ and SEQ both have HTRANS[1] set
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_err_logger.sv
// ============================================================================
//  ahb_err_logger
//  Records the first erroring transfer and counts ERROR responses (saturating).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_err_logger #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              entry_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]  count_o
);

  logic              valid_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;

  // Clear wins over a coincident error, which is then simply lost
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (entry_i) begin
      if (!valid_q) begin
        valid_q <= 1'b1;
        write_q <= write_i;
        addr_q  <= addr_i;
      end
      if (count_q != {CNT_W{1'b1}}) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign valid_o = valid_q;
  assign write_o = write_q;
  assign addr_o  = addr_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ahb_error_slave.sv
// ============================================================================
//  ahb_error_slave
//  AHB-Lite default slave: answers every active transfer with a two-cycle
//  ERROR response after optional wait states. Optional logging is compiled
//  in with the macro DEFSLV_ERR_LOG_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_error_slave
  import ahb_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] ERR_DATA    = '1,
  parameter int                CNT_W       = 16
) (
  input  logic              HMASTCLOCK,
  input  logic              resetn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
`ifdef DEFSLV_ERR_LOG_EN
  ,
  input  logic              err_clr,
  output logic              err_valid,
  output logic              err_write,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int             CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0]  WS_C = CW'(WAIT_STATES);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              write_q;
  logic              hreadyout_q;
  logic              hresp_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              w_sample;

  assign w_sample = HSEL & HREADY & htrans_active(HTRANS);

  // Outputs are registered from the next state so each state's response
  // appears in the cycle the state is occupied.
  always_ff @(posedge HMASTCLOCK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= c_hresp_okay;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          hrdata_q <= '0;
          if (w_sample) begin
            write_q     <= HWRITE;
            hreadyout_q <= 1'b0;
            if (WAIT_STATES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= CW'(1);
              hresp_q <= c_hresp_okay;
            end else begin
              state_q <= ST_ERR1;
              hresp_q <= c_hresp_error;
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= c_hresp_okay;
          end
        end
        ST_WAIT: begin
          if (cnt_q == WS_C) begin
            state_q <= ST_ERR1;
            cnt_q   <= '0;
            hresp_q <= c_hresp_error;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= c_hresp_error;
          hrdata_q    <= write_q ? '0 : ERR_DATA;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= c_hresp_okay;
          hrdata_q    <= '0;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

`ifdef DEFSLV_ERR_LOG_EN
  logic [ADDR_W-1:0] addr_q;
  logic              w_err1_entry;
  logic              w_log_write;
  logic [ADDR_W-1:0] w_log_addr;

  always_ff @(posedge HMASTCLOCK or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else if ((state_q == ST_IDLE || state_q == ST_ERR2) && w_sample) begin
      addr_q <= HADDR;
    end
  end

  // Strobe on the edge that moves the FSM into ERR1; with no wait states the
  // transfer attributes are still on the bus, otherwise use the held copy.
  always_comb begin
    w_err1_entry = 1'b0;
    w_log_write  = write_q;
    w_log_addr   = addr_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (w_sample && (WAIT_STATES == 0)) begin
          w_err1_entry = 1'b1;
          w_log_write  = HWRITE;
          w_log_addr   = HADDR;
        end
      end
      ST_WAIT: w_err1_entry = (cnt_q == WS_C);
      default: w_err1_entry = 1'b0;
    endcase
  end

  ahb_err_logger #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_logger (
    .clk_i   (HMASTCLOCK),
    .rst_ni  (resetn),
    .clr_i   (err_clr),
    .entry_i (w_err1_entry),
    .write_i (w_log_write),
    .addr_i  (w_log_addr),
    .valid_o (err_valid),
    .write_o (err_write),
    .addr_o  (err_addr),
    .count_o (err_count)
  );
`endif

  logic w_unused;
  assign w_unused = ^{HTRANS[0], HSIZE, HBURST, HPROT, HWDATA, HADDR};

endmodule

`default_nettype wire

// File: tb/tb_ahb_error_slave.sv
// ============================================================================
//  tb_ahb_error_slave
//  Self-checking bench: a zero-wait slave (CNT_W=2) and a three-wait slave.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_error_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel, hwrite, err_clr;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata = 32'h0;
  logic [2:0]  hsize  = 3'b010;
  logic [2:0]  hburst = 3'b000;
  logic [3:0]  hprot  = 4'b0011;

  logic        a_rdy, a_resp, b_rdy, b_resp;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, a_write, b_valid, b_write;
  logic [31:0] a_addr, b_addr;
  logic [1:0]  a_count;
  logic [15:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_error_slave #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0), .CNT_W(2)) u_dut_a (
    .HMASTCLOCK (clk),    .resetn (resetn),   .HSEL (hsel),       .HREADY (a_rdy),
    .HWRITE     (hwrite), .HTRANS (htrans),   .HSIZE (hsize),     .HBURST (hburst),
    .HPROT      (hprot),  .HADDR  (haddr),    .HWDATA (hwdata),   .HRDATA (a_rdata),
    .HREADYOUT  (a_rdy),  .HRESP  (a_resp)
`ifdef DEFSLV_ERR_LOG_EN
    , .err_clr (err_clr), .err_valid (a_valid), .err_write (a_write),
    .err_addr (a_addr), .err_count (a_count)
`endif
  );

  ahb_error_slave #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(3)) u_dut_b (
    .HMASTCLOCK (clk),    .resetn (resetn),   .HSEL (hsel),       .HREADY (b_rdy),
    .HWRITE     (hwrite), .HTRANS (htrans),   .HSIZE (hsize),     .HBURST (hburst),
    .HPROT      (hprot),  .HADDR  (haddr),    .HWDATA (hwdata),   .HRDATA (b_rdata),
    .HREADYOUT  (b_rdy),  .HRESP  (b_resp)
`ifdef DEFSLV_ERR_LOG_EN
    , .err_clr (err_clr), .err_valid (b_valid), .err_write (b_write),
    .err_addr (b_addr), .err_count (b_count)
`endif
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    hsel    = 1'b0;
    htrans  = T_IDLE;
    hwrite  = 1'b0;
    haddr   = 32'h0;
    err_clr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // sel trans wr addr | rdy resp rdata (outputs after the cycle's closing edge)
    vecs[0]  = '{1'b1, T_IDLE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, T_BUSY, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, T_NSEQ, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, T_NSEQ, 1'b0, 32'h0000_1000, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, T_NSEQ, 1'b0, 32'h0000_2000, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, T_IDLE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, T_NSEQ, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, T_IDLE, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, T_SEQ,  1'b0, 32'h0000_0020, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, T_IDLE, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, T_IDLE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};

    // Reset values, held across clock edges
    resetn = 1'b0; hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b0; haddr = 32'h0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rdy", a_rdy, 1); chk("rst_a_resp", a_resp, 0); chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdy", b_rdy, 1); chk("rst_b_resp", b_resp, 0); chk("rst_b_rdata", b_rdata, 0);
`ifdef DEFSLV_ERR_LOG_EN
    chk("rst_valid", a_valid, 0); chk("rst_write", a_write, 0);
    chk("rst_addr", a_addr, 0);   chk("rst_count", a_count, 0);
`endif
    do_reset();

    // Zero-wait slave: idle/busy/unselected, read error, write error, back-to-back
    for (int i = 0; i < 11; i++) begin
      hsel = vecs[i].sel; htrans = vecs[i].trans; hwrite = vecs[i].wr; haddr = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_rdy", i),   a_rdy,   vecs[i].rdy);
      chk($sformatf("vec%0d_resp", i),  a_resp,  vecs[i].resp);
      chk($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].rdata);
    end

    // Three-wait slave: write then read, 3 wait cycles, ERR1, ERR2
    for (int w = 1; w >= 0; w--) begin
      do_reset();
      hsel = 1'b1; htrans = T_NSEQ; hwrite = logic'(w); haddr = 32'h0000_0040;
      for (int j = 0; j < 5; j++) begin
        tick();
        htrans = T_IDLE;
        chk($sformatf("ws3_w%0d_c%0d_rdy", w, j),  b_rdy,  (j == 4) ? 1 : 0);
        chk($sformatf("ws3_w%0d_c%0d_resp", w, j), b_resp, (j >= 3) ? 1 : 0);
        chk($sformatf("ws3_w%0d_c%0d_rdata", w, j), b_rdata,
            (j == 4 && w == 0) ? 64'hFFFF_FFFF : 64'h0);
      end
      tick();
      chk($sformatf("ws3_w%0d_done_rdy", w), b_rdy, 1);
      chk($sformatf("ws3_w%0d_done_resp", w), b_resp, 0);
    end

    // Reset asserted during ERR1: immediate reset values, no ERR2 afterwards
    do_reset();
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b0; haddr = 32'h0000_1000;
    tick();
    htrans = T_IDLE;
    chk("rstmid_err1_rdy", a_rdy, 0); chk("rstmid_err1_resp", a_resp, 1);
    resetn = 1'b0;
    #1;
    chk("rstmid_now_rdy", a_rdy, 1); chk("rstmid_now_resp", a_resp, 0);
    chk("rstmid_now_rdata", a_rdata, 0);
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rstmid_after_rdy", a_rdy, 1); chk("rstmid_after_resp", a_resp, 0);
    chk("rstmid_after_rdata", a_rdata, 0);

`ifdef DEFSLV_ERR_LOG_EN
    // First capture sticks; second error counted back-to-back from ERR2
    do_reset();
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h0000_0010;
    tick();
    chk("log1_count", a_count, 1); chk("log1_valid", a_valid, 1);
    chk("log1_addr", a_addr, 32'h10); chk("log1_write", a_write, 1);
    hwrite = 1'b0; haddr = 32'h0000_0020;
    tick();
    chk("log_err2_rdy", a_rdy, 1); chk("log_err2_resp", a_resp, 1);
    tick();
    htrans = T_IDLE;
    chk("log2_rdy", a_rdy, 0); chk("log2_resp", a_resp, 1);
    chk("log2_count", a_count, 2); chk("log2_addr", a_addr, 32'h10);
    chk("log2_write", a_write, 1);
    tick(); tick();
    // Three more errors: five total saturates a 2-bit counter at 3
    for (int k = 0; k < 3; k++) begin
      htrans = T_NSEQ;
      tick();
      htrans = T_IDLE;
      tick(); tick();
    end
    chk("log_sat_count", a_count, 3); chk("log_sat_addr", a_addr, 32'h10);
    // Clear coincident with an ERR1 entry drops that error
    htrans = T_NSEQ; haddr = 32'h0000_0030; err_clr = 1'b1;
    tick();
    err_clr = 1'b0; htrans = T_IDLE;
    chk("clr_count", a_count, 0); chk("clr_valid", a_valid, 0);
    chk("clr_err1_resp", a_resp, 1);
    tick(); tick();
    htrans = T_NSEQ; haddr = 32'h0000_0044; hwrite = 1'b0;
    tick();
    htrans = T_IDLE;
    chk("recap_count", a_count, 1); chk("recap_valid", a_valid, 1);
    chk("recap_addr", a_addr, 32'h44); chk("recap_write", a_write, 0);
    tick(); tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_error_slave.md
AHB_ERROR_SLAVE -- requirements
Module: ahb_error_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning HRDATA/HWDATA width; only 32 or 64 are legal.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning HADDR width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning number of OKAY wait cycles (0..15) inserted before the ERROR response.
REQ-004 SHALL have parameter ERR_DATA, default all ones, meaning the HRDATA value driven during the ERROR response.
REQ-005 SHALL have parameter CNT_W, default 16, meaning error counter width.
REQ-006 SHALL have the port HMASTCLOCK  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have the port resetn  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have the ports HSEL, HREADY, HWRITE  in  1 each  standard AHB-Lite slave inputs.
REQ-009 SHALL have the ports HTRANS in 2, HSIZE in 3, HBURST in 3, HPROT in 4, HADDR in ADDR_W, HWDATA in DATA_W; HSIZE/HBURST/HPROT/HWDATA are ignored.
REQ-010 SHALL have the ports HRDATA  out  DATA_W, HREADYOUT  out  1, HRESP  out  1.
REQ-011 SHALL, when logging is compiled in, have the ports err_clr in 1, err_valid out 1, err_write out 1, err_addr out ADDR_W, err_count out CNT_W.

Function
REQ-012 SHALL sample a transfer only when HSEL=1 and HREADY=1 at a rising edge; the transfer is "active" when HTRANS is NONSEQ or SEQ.
REQ-013 SHALL answer IDLE/BUSY transfers and unselected cycles with HREADYOUT=1, HRESP=0 (OKAY), zero wait.
REQ-014 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-015 SHALL transition IDLE->WAIT on an active transfer when WAIT_STATES>0, and IDLE->ERR1 when WAIT_STATES=0.
REQ-016 SHALL hold WAIT for exactly WAIT_STATES cycles with HREADYOUT=0 and HRESP=0, then go to ERR1.
REQ-017 SHALL drive ERR1 as HREADYOUT=0, HRESP=1 (one cycle), then go to ERR2.
REQ-018 SHALL drive ERR2 as HREADYOUT=1, HRESP=1, and HRDATA=ERR_DATA when the transfer is a read.
REQ-019 SHALL leave ERR2 for WAIT or ERR1 if an active transfer is sampled in the ERR2 cycle, and otherwise for IDLE; back-to-back errors have no idle gap.
REQ-020 SHALL ignore HSEL/HTRANS in WAIT and ERR1, since HREADY is low.
REQ-021 SHALL drive HRDATA=0 in every state other than ERR2-read.
REQ-022 SHALL size the wait counter to clog2(WAIT_STATES+1) bits, with no wrap.

Reset
REQ-023 SHALL, on resetn low, immediately force state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, err_valid=0, err_write=0, err_addr=0, err_count=0.
REQ-024 SHALL, on reset assertion mid-WAIT, ERR1 or ERR2, abandon the transfer with no ERROR completion; the first cycle after release is IDLE.

Configuration
REQ-025 SHALL gate the logging ports and registers with the macro DEFSLV_ERR_LOG_EN.
REQ-026 SHALL, with DEFSLV_ERR_LOG_EN defined, capture HADDR/HWRITE of the first erroring transfer into err_addr/err_write at its ERR1 entry and set err_valid; later errors do not overwrite the capture until err_clr.
REQ-027 SHALL, with DEFSLV_ERR_LOG_EN defined, increment err_count once per ERR1 entry, saturating at all ones.
REQ-028 SHALL give err_clr=1 priority over capture and increment in the same cycle: it clears err_valid and err_count, and the simultaneous error is dropped.
REQ-029 SHALL, without DEFSLV_ERR_LOG_EN, have no logging ports or registers, with the AHB behaviour unchanged.

Structure
REQ-030 SHALL place the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), the HRESP encodings (OKAY, ERROR) and the FSM state typedef in shared package ahb_pkg.
REQ-031 SHALL implement logging in a sub-module ahb_err_logger, instantiated only under DEFSLV_ERR_LOG_EN.

Verification
REQ-032 SHALL cover: WAIT_STATES=0, NONSEQ read at 0x0000_1000 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1, HRDATA=0xFFFF_FFFF).
REQ-033 SHALL cover: WAIT_STATES=3, NONSEQ write -> 3 cycles HREADYOUT=0/HRESP=0, then ERR1, then ERR2; HRDATA stays 0.
REQ-034 SHALL cover: HTRANS=IDLE then BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0 every cycle, err_count stays 0.
REQ-035 SHALL cover: NONSEQ at 0x10 then NONSEQ at 0x20 sampled in ERR2 -> second ERR1 follows immediately, err_count=2, err_addr=0x10.
REQ-036 SHALL cover: resetn low in the ERR1 cycle -> outputs at reset values at once, IDLE after release, no ERR2 issued.
REQ-037 SHALL cover: CNT_W=2 with 5 errors -> err_count=3; err_clr coincident with an ERR1 entry -> err_count=0, err_valid=0.
